// File: rtl/rpn_sequencer.sv
// RPN program sequencer: replays a stored program as one push/op command per
// step to the stack calculator, tracking stack depth to refuse unsafe commands.
module rpn_sequencer #(
  parameter int PROG_DEPTH = 64,
  parameter int ADDR_W     = 6,
  parameter int STK_MAX    = 1024
) (
  input  logic               step,
  input  logic               nrst,
  input  logic               start,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [17:0]        prog_wdata,
  input  logic signed [15:0] stk_top,
  output logic               push,
  output logic [1:0]         op,
  output logic signed [15:0] d,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [1:0]         err_code,
  output logic signed [15:0] result,
  output logic [ADDR_W-1:0]  pc
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

  localparam logic [10:0]       DEPTH_MAX = 11'(STK_MAX);
  localparam logic [ADDR_W-1:0] PC_LAST   = ADDR_W'(PROG_DEPTH - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [10:0]        depth_q, depth_d;
  logic signed [15:0] result_q, result_d;
  logic [1:0]         err_q, err_d;

  logic [17:0] mem_q [PROG_DEPTH];
  logic [17:0] instr;
  logic [1:0]  opc;
  logic [15:0] pay;
  logic        ok, fault;
  logic [1:0]  fcode;

  // Program store is not reset; writes are locked out while executing.
  always_ff @(posedge step) begin
    if (prog_we && state_q != S_RUN) mem_q[prog_addr] <= prog_wdata;
  end

  assign instr = mem_q[pc_q];
  assign opc   = instr[17:16];
  assign pay   = instr[15:0];

  always_ff @(posedge step or negedge nrst) begin
    if (!nrst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      depth_q  <= '0;
      result_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      depth_q  <= depth_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    depth_d  = depth_q;
    result_d = result_q;
    err_d    = err_q;
    push     = 1'b0;
    op       = 2'd0;
    d        = '0;
    ok       = 1'b0;
    fault    = 1'b0;
    fcode    = 2'd0;
    case (state_q)
      S_RUN: begin
        // ok marks an instruction that issued (or NOP) and may advance pc.
        case (opc)
          2'b00: begin
            if (depth_q == DEPTH_MAX) begin
              fault = 1'b1;
              fcode = 2'd2;
            end else begin
              push    = 1'b1;
              d       = pay;
              depth_d = depth_q + 11'd1;
              ok      = 1'b1;
            end
          end
          2'b01: begin
            case (pay[1:0])
              2'd0: ok = 1'b1;
              2'd1: begin
                if (depth_q == 11'd0) begin
                  fault = 1'b1;
                  fcode = 2'd1;
                end else begin
                  op = 2'd1;
                  ok = 1'b1;
                end
              end
              default: begin
                if (depth_q < 11'd2) begin
                  fault = 1'b1;
                  fcode = 2'd1;
                end else begin
                  op      = pay[1:0];
                  depth_d = depth_q - 11'd1;
                  ok      = 1'b1;
                end
              end
            endcase
          end
          2'b10: begin
            if (depth_q == 11'd0) begin
              fault = 1'b1;
              fcode = 2'd1;
            end else begin
              result_d = stk_top;
              state_d  = S_DONE;
            end
          end
          default: begin
            fault = 1'b1;
            fcode = 2'd3;
          end
        endcase
        if (fault) begin
          state_d = S_ERR;
          err_d   = fcode;
        end else if (ok) begin
          // Falling off the end of the program is a runaway, never a wrap.
          if (pc_q == PC_LAST) begin
            state_d = S_ERR;
            err_d   = 2'd3;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          err_d   = 2'd0;
        end
      end
    endcase
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign error    = (state_q == S_ERR);
  assign err_code = err_q;
  assign result   = result_q;
  assign pc       = pc_q;

endmodule

// File: tb/tb_rpn_sequencer.sv
// Scoreboard bench for rpn_sequencer: a program interpreter predicts commands
// and outcomes, a behavioural calculator answers stk_top, a monitor compares.
module tb_rpn_sequencer;
  localparam int PD = 64, AW = 6, SMAX = 1024;

  logic step = 1'b0, nrst = 1'b0, start = 1'b0, prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [17:0] prog_wdata = '0;
  logic signed [15:0] stk_top;
  logic push, busy, done, error;
  logic [1:0] op, err_code;
  logic signed [15:0] d, result;
  logic [AW-1:0] pc;

  rpn_sequencer #(.PROG_DEPTH(PD), .ADDR_W(AW), .STK_MAX(SMAX)) dut (
    .step(step), .nrst(nrst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .stk_top(stk_top),
    .push(push), .op(op), .d(d), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .result(result), .pc(pc));

  always #5 step = ~step;

  typedef struct packed {logic push; logic [1:0] op; logic [15:0] d;} cmd_t;
  typedef struct {bit is_err; int code; int pc; int cycles; logic [15:0] result;} out_t;

  cmd_t exp_cmd[$];
  out_t exp_out[$];
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural calculator standing in for the real stack unit.
  logic signed [15:0] calc_stk[$];
  logic signed [15:0] calc_top = '0;
  assign stk_top = calc_top;
  always @(negedge step or negedge nrst) begin
    logic signed [15:0] ca, cb;
    if (!nrst) begin
      calc_stk.delete();
    end else if (push) begin
      calc_stk.push_back(d);
    end else if (op == 2'd1 && calc_stk.size() > 0) begin
      calc_stk[$] = -calc_stk[$];
    end else if (op[1] && calc_stk.size() > 1) begin
      cb = calc_stk.pop_back();
      ca = calc_stk.pop_back();
      calc_stk.push_back(op[0] ? ca * cb : ca + cb);
    end
    calc_top = (calc_stk.size() > 0) ? calc_stk[$] : 16'sd0;
  end

  // Reference interpreter over the mirrored program image.
  logic [17:0] prog[PD];
  logic signed [15:0] ref_stk[$];
  logic [15:0] ref_result = '0;

  task automatic model_run();
    int p;
    bit fin;
    out_t o;
    cmd_t c;
    logic [17:0] w;
    logic signed [15:0] a, b;
    p = 0; fin = 0; o.is_err = 0; o.code = 0;
    while (!fin) begin
      w = prog[p];
      c.push = 1'b0; c.op = 2'd0; c.d = 16'd0;
      case (w[17:16])
        2'b00: if (ref_stk.size() == SMAX) begin o.is_err = 1; o.code = 2; fin = 1; end
               else begin ref_stk.push_back(w[15:0]); c.push = 1'b1; c.d = w[15:0]; exp_cmd.push_back(c); end
        2'b01: begin
          if (w[1:0] == 2'd1) begin
            if (ref_stk.size() < 1) begin o.is_err = 1; o.code = 1; fin = 1; end
            else begin ref_stk[$] = -ref_stk[$]; c.op = 2'd1; exp_cmd.push_back(c); end
          end else if (w[1:0] != 2'd0) begin
            if (ref_stk.size() < 2) begin o.is_err = 1; o.code = 1; fin = 1; end
            else begin
              b = ref_stk.pop_back(); a = ref_stk.pop_back();
              ref_stk.push_back(w[1:0] == 2'd2 ? a + b : a * b);
              c.op = w[1:0]; exp_cmd.push_back(c);
            end
          end
        end
        2'b10: begin
          if (ref_stk.size() == 0) begin o.is_err = 1; o.code = 1; end
          else ref_result = ref_stk[$];
          fin = 1;
        end
        default: begin o.is_err = 1; o.code = 3; fin = 1; end
      endcase
      if (!fin && p == PD - 1) begin o.is_err = 1; o.code = 3; fin = 1; end
      if (!fin) p++;
    end
    o.pc = p; o.cycles = p + 1; o.result = ref_result;
    exp_out.push_back(o);
  endtask

  // Monitor: compares every issued command and every run outcome.
  bit prev_busy = 0;
  int bcnt = 0;
  always @(negedge step or negedge nrst) begin
    cmd_t c;
    out_t o;
    if (!nrst) begin
      prev_busy = 0; bcnt = 0;
    end else begin
      if (busy) begin
        bcnt++;
        if (push || op != 2'd0) begin
          if (exp_cmd.size() == 0) chk("cmd_unexpected", {13'd0, push, op, d}, 32'd0);
          else begin c = exp_cmd.pop_front(); chk("cmd", {13'd0, push, op, d}, {13'd0, c}); end
        end
      end else begin
        chk("idle_cmd_zero", {13'd0, push, op, d}, 32'd0);
        if (prev_busy) begin
          if (exp_out.size() == 0) chk("outcome_unexpected", 32'd1, 32'd0);
          else begin
            o = exp_out.pop_front();
            chk("done", {31'd0, done}, {31'd0, !o.is_err});
            chk("error", {31'd0, error}, {31'd0, o.is_err});
            chk("err_code", {30'd0, err_code}, o.code);
            chk("pc", {26'd0, pc}, o.pc);
            chk("busy_cycles", bcnt, o.cycles);
            chk("result", {16'd0, result}, {16'd0, o.result});
            chk("cmds_left", exp_cmd.size(), 32'd0);
          end
        end
        bcnt = 0;
      end
      prev_busy = busy;
    end
  end

  function automatic logic [17:0] P(input logic [15:0] v); return {2'b00, v}; endfunction
  function automatic logic [17:0] A(input logic [1:0] k); return {2'b01, 14'd0, k}; endfunction
  localparam logic [17:0] H = {2'b10, 16'd0};
  localparam logic [17:0] ILL = {2'b11, 16'h1234};

  task automatic tick(); @(posedge step); #1; endtask

  task automatic wr(input int a, input logic [17:0] w);
    prog_we = 1'b1; prog_addr = AW'(a); prog_wdata = w;
    tick();
    prog_we = 1'b0;
    prog[a] = w;
  endtask

  task automatic wait_out(input int budget);
    int n;
    n = 0;
    while (exp_out.size() != 0 && n < budget) begin tick(); n++; end
    if (exp_out.size() != 0) begin
      chk("timeout", 32'd1, 32'd0);
      exp_out.delete(); exp_cmd.delete();
    end
  endtask

  task automatic run();
    model_run();
    start = 1'b1; tick(); start = 1'b0;
    wait_out(200);
    tick();
  endtask

  task automatic do_reset();
    nrst = 1'b0; #1;
    exp_cmd.delete(); exp_out.delete(); ref_stk.delete(); ref_result = '0;
    tick(); nrst = 1'b1; tick();
  endtask

  initial begin
    int n;
    tick(); tick();
    chk("rst_outputs", {13'd0, push, op, d}, 32'd0);
    chk("rst_status", {26'd0, busy, done, error, err_code, 1'b0}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_pc", {26'd0, pc}, 32'd0);
    nrst = 1'b1; tick();
    for (int i = 0; i < PD; i++) wr(i, H);

    // (3+4)*-2 = -14
    wr(0, P(16'd3)); wr(1, P(16'd4)); wr(2, A(2'd2)); wr(3, P(16'hFFFE)); wr(4, A(2'd3)); wr(5, H);
    run();
    chk("t1_result", {16'd0, result}, 32'h0000FFF2);
    chk("t1_pc", {26'd0, pc}, 32'd5);

    // neg on empty stack
    do_reset();
    wr(0, A(2'd1)); wr(1, H);
    run();

    // neg then add with one entry faults at pc 2
    wr(0, P(16'd5)); wr(1, A(2'd1)); wr(2, A(2'd2)); wr(3, H);
    run();
    chk("t3_pc", {26'd0, pc}, 32'd2);

    // illegal opcode
    wr(0, ILL);
    run();
    chk("t4_code", {30'd0, err_code}, 32'd3);

    // runaway through all-NOP program
    for (int i = 0; i < PD; i++) wr(i, A(2'd0));
    run();
    chk("t5_pc", {26'd0, pc}, 32'd63);

    // reset mid-run at pc 3, then rerun from address 0
    do_reset();
    for (int i = 0; i < 5; i++) wr(i, P(16'(i + 1)));
    wr(5, H);
    model_run();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (pc != AW'(3) && n < 20) begin tick(); n++; end
    chk("t6_reached_pc3", {26'd0, pc}, 32'd3);
    nrst = 1'b0; #1;
    chk("t6_busy_drop", {29'd0, busy, push, op != 2'd0}, 32'd0);
    chk("t6_pc_zero", {26'd0, pc}, 32'd0);
    exp_cmd.delete(); exp_out.delete(); ref_stk.delete(); ref_result = '0;
    tick(); nrst = 1'b1; tick();
    run();
    chk("t6_rerun_result", {16'd0, result}, 32'd5);

    // program write during RUN is ignored
    wr(0, P(16'd7)); wr(1, P(16'd8)); wr(2, A(2'd2)); wr(3, A(2'd0)); wr(4, H);
    model_run();
    start = 1'b1; tick(); start = 1'b0;
    tick();
    prog_we = 1'b1; prog_addr = pc + AW'(1); prog_wdata = H;
    tick(); prog_we = 1'b0;
    wait_out(200); tick();
    run();

    // write and start in the same cycle: the write lands first
    wr(1, P(16'd20)); wr(2, A(2'd3)); wr(3, H);
    prog[0] = P(16'hFFFD);
    model_run();
    prog_we = 1'b1; prog_addr = '0; prog_wdata = P(16'hFFFD); start = 1'b1;
    tick(); prog_we = 1'b0; start = 1'b0;
    wait_out(200); tick();
    chk("t8_result", {16'd0, result}, 32'h0000FFC4);

    // overflow: depth accumulates across programs until STK_MAX
    do_reset();
    for (int i = 0; i < PD - 1; i++) wr(i, P(16'($urandom)));
    wr(PD - 1, H);
    for (int r = 0; r < 17; r++) run();
    chk("t9_code", {30'd0, err_code}, 32'd2);
    chk("t9_pc", {26'd0, pc}, 32'd16);

    // randomized programs
    do_reset();
    for (int it = 0; it < 40; it++) begin
      int len, r;
      if (it % 10 == 9) do_reset();
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 19);
        if (r < 8) wr(i, P(16'($urandom)));
        else if (r < 17) wr(i, A(2'($urandom)));
        else if (r < 18) wr(i, ILL);
        else wr(i, A(2'd0));
      end
      if (it % 7 != 3) wr(len, H);
      run();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rpn_sequencer.md
Name: rpn_sequencer

Overview:
- Command initiator for the stack calculator: holds a small RPN program and replays it as one push/op command per cycle.
- Drives the calculator's push, op and d inputs and reads its top-of-stack output.
- Tracks stack depth itself, so commands that would underflow or overflow the calculator are never issued; it stops with an error instead.
- Captures the final top-of-stack on HALT and reports done or error to the host.

Parameters:
- PROG_DEPTH, 64, number of program words.
- ADDR_W, 6, program address width; must satisfy 2^ADDR_W = PROG_DEPTH.
- STK_MAX, 1024, maximum calculator depth (top register plus 1023 memory entries).

Ports:
- step  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  begin execution at pc=0; honoured in IDLE, DONE or ERROR only.
- prog_we  in  1  program write strobe; honoured in IDLE, DONE or ERROR only.
- prog_addr  in  ADDR_W  program write address.
- prog_wdata  in  18  instruction word.
- stk_top  in  16 signed  calculator top-of-stack.
- push  out  1  calculator push command.
- op  out  2  calculator op: 0 none, 1 neg, 2 add, 3 mul.
- d  out  16 signed  calculator push data.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- error  out  1  high in ERROR.
- err_code  out  2  1 underflow, 2 overflow, 3 illegal or runaway; 0 otherwise.
- result  out  16 signed  top-of-stack captured at HALT.
- pc  out  ADDR_W  current program counter.

Behaviour:
- Instruction word fields: [17:16] opcode, [15:0] payload.
  - 00 PUSH: d = payload.
  - 01 ALU: op = payload[1:0]; payload 0 is a NOP.
  - 10 HALT.
  - 11 illegal.
- Program memory: PROG_DEPTH x 18. Written on the step edge when prog_we is high and the state is not RUN. Read combinationally at pc. Contents are not reset.
- States: IDLE, RUN, DONE, ERROR.
- Reset (async, nrst=0): state IDLE, pc=0, depth=0, result=0, err_code=0; push=0, op=0, d=0, busy=0, done=0, error=0. Reset mid-RUN aborts immediately, and outputs go to 0 asynchronously.
- IDLE, DONE, ERROR:
  - push, op and d are held at 0.
  - start=1 moves to RUN with pc=0 on the next edge.
  - err_code clears on start; result holds until the next HALT.
  - start and prog_we in the same cycle: both are honoured (the write lands; execution begins next cycle).
- RUN: one instruction per cycle. Commands are combinational from the current instruction and take effect at the same step edge that advances pc.
  - PUSH:
    - depth == STK_MAX: issue nothing, go to ERROR, err_code=2.
    - Otherwise push=1, d=payload, depth+1, pc+1.
  - ALU neg (payload 1):
    - depth < 1: issue nothing, go to ERROR, err_code=1.
    - Otherwise op=1, depth unchanged.
  - ALU add/mul (payload 2 or 3):
    - depth < 2: issue nothing, go to ERROR, err_code=1.
    - Otherwise op=payload, depth-1.
  - ALU NOP: op=0, pc+1.
  - HALT:
    - depth == 0: go to ERROR, err_code=1.
    - Otherwise result <= stk_top, go to DONE. No command is issued.
  - Illegal opcode: go to ERROR, err_code=3.
  - pc == PROG_DEPTH-1 and the instruction is not HALT and does not error: the instruction is issued, then go to ERROR with err_code=3 (runaway). pc does not wrap.
- start and prog_we are ignored while in RUN.
- pc holds its value on entering DONE or ERROR, pointing at the HALT or faulting instruction.
- depth persists across programs and is cleared only by nrst. It is modelled as 11 bits, saturating is never reached because of the overflow check.
- All arithmetic is done by the calculator; this block only sequences commands.
- Latency: a program of N instructions ending in HALT asserts done exactly N cycles after the start edge.

Test Plan:
- Load PUSH 3, PUSH 4, ADD, PUSH -2, MUL, HALT; pulse start -> busy for 6 cycles; done=1; result = -14 (0xFFF2); pc=5; depth=1.
- After reset, load ALU neg, HALT; start -> error=1, err_code=1 in cycle 1; push and op never asserted; pc=0.
- Load PUSH 5, ALU neg, ALU add, HALT -> neg issued (op=1); ADD faults: error, err_code=1, pc=2; result unchanged.
- Load opcode 11 at address 0 -> ERROR, err_code=3. Separately, fill the program with NOPs and no HALT -> ERROR, err_code=3 with pc=63 after 64 cycles.
- Assert nrst=0 mid-RUN at pc=3 -> busy, push and op drop immediately; pc=0 and depth=0. A following start re-runs the program from address 0.
- Assert prog_we during RUN writing HALT to the current pc -> ignored, and the program completes as originally loaded.
